// File: rtl/alu_cnt_dec_unit.sv
// ---------------------------------------------------------------------------
// alu_cnt_dec_unit
//
// Bring-up utility datapath made of three independent blocks that share
// only clk and rst:
//   * 4-bit two's-complement ALU with zero / overflow / carry flags
//   * 3-bit enabled down-counter (reset value 3'b111, wraps 000 -> 111)
//   * 3-to-8 one-hot decoder with enable
//
// Optional build macro: ALU_OUTPUT_REG_EN
//   defined   : ALU result and flags are registered (1-cycle latency),
//               rst clears all four ALU outputs to 0
//   undefined : ALU outputs are purely combinational, no reset state
//
// Ports
//   clk             in  1  rising-edge clock
//   rst             in  1  synchronous active-high reset
//   alu_fnselec     in  3  ALU operation select
//   alu_a, alu_b    in  4  ALU operands (two's complement)
//   alu_res         out 4  ALU result
//   alu_zero        out 1  result == 0
//   alu_overflow    out 1  signed overflow (add/sub only)
//   alu_carry       out 1  carry-out / no-borrow (add/sub only)
//   counter_en      in  1  down-counter enable
//   dec_counter_out out 3  down-counter value
//   x               in  3  decoder select
//   en              in  1  decoder enable
//   y_dec           out 8  one-hot decoder output
// ---------------------------------------------------------------------------
module alu_cnt_dec_unit (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] alu_fnselec,
   input  logic [3:0] alu_a,
   input  logic [3:0] alu_b,
   output logic [3:0] alu_res,
   output logic       alu_zero,
   output logic       alu_overflow,
   output logic       alu_carry,
   input  logic       counter_en,
   output logic [2:0] dec_counter_out,
   input  logic [2:0] x,
   input  logic       en,
   output logic [7:0] y_dec
);

   // ------------------------------------------------------------------
   // ALU datapath
   // ------------------------------------------------------------------
   logic [4:0] w_add_sum;
   logic [4:0] w_sub_sum;
   logic       w_add_ov;
   logic       w_sub_ov;
   logic [3:0] w_res;
   logic       w_overflow;
   logic       w_carry;
   logic       w_zero;

   // Subtraction is A + ~B + 1 so that bit 4 is the "no borrow" flag.
   assign w_add_sum = {1'b0, alu_a} + {1'b0, alu_b};
   assign w_sub_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
   assign w_add_ov  = (alu_a[3] == alu_b[3]) && (w_add_sum[3] != alu_a[3]);
   assign w_sub_ov  = (alu_a[3] != alu_b[3]) && (w_sub_sum[3] != alu_a[3]);

   always_comb begin
      w_res      = 4'h0;
      w_overflow = 1'b0;
      w_carry    = 1'b0;
      case (alu_fnselec)
         3'b000: begin
            w_res      = w_add_sum[3:0];
            w_overflow = w_add_ov;
            w_carry    = w_add_sum[4];
         end
         3'b001: begin
            w_res      = w_sub_sum[3:0];
            w_overflow = w_sub_ov;
            w_carry    = w_sub_sum[4];
         end
         3'b010: w_res = ~alu_a;
         3'b011: w_res = alu_a & alu_b;
         3'b100: w_res = alu_a | alu_b;
         3'b101: w_res = alu_a ^ alu_b;
         // Signed less-than: sign of A-B corrected by its overflow.
         3'b110: w_res = {3'b000, w_sub_sum[3] ^ w_sub_ov};
         default: w_res = {3'b000, alu_a == alu_b};
      endcase
   end

   assign w_zero = (w_res == 4'h0);

`ifdef ALU_OUTPUT_REG_EN
   logic [3:0] r_alu_res;
   logic       r_alu_zero;
   logic       r_alu_overflow;
   logic       r_alu_carry;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_alu_res      <= 4'h0;
         r_alu_zero     <= 1'b0;
         r_alu_overflow <= 1'b0;
         r_alu_carry    <= 1'b0;
      end else begin
         r_alu_res      <= w_res;
         r_alu_zero     <= w_zero;
         r_alu_overflow <= w_overflow;
         r_alu_carry    <= w_carry;
      end
   end

   assign alu_res      = r_alu_res;
   assign alu_zero     = r_alu_zero;
   assign alu_overflow = r_alu_overflow;
   assign alu_carry    = r_alu_carry;
`else
   assign alu_res      = w_res;
   assign alu_zero     = w_zero;
   assign alu_overflow = w_overflow;
   assign alu_carry    = w_carry;
`endif

   // ------------------------------------------------------------------
   // Down-counter: reset has priority over enable; 000 wraps to 111
   // naturally through 3-bit modular subtraction.
   // ------------------------------------------------------------------
   logic [2:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= 3'b111;
      end else if (counter_en) begin
         r_cnt <= r_cnt - 3'd1;
      end
   end

   assign dec_counter_out = r_cnt;

   // ------------------------------------------------------------------
   // One-hot decoder
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_dec
         assign y_dec[gi] = en && (x == 3'(gi));
      end
   endgenerate

endmodule

// File: tb/tb_alu_cnt_dec_unit.sv
// ---------------------------------------------------------------------------
// Self-checking bench for alu_cnt_dec_unit.
// ALU vectors are table driven; counter and decoder use short directed
// sequences. When ALU_OUTPUT_REG_EN is defined, ALU results are checked one
// clock after the operands are applied, plus a latency/reset sequence.
// ---------------------------------------------------------------------------
module tb_alu_cnt_dec_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] alu_fnselec;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [3:0] alu_res;
   logic       alu_zero;
   logic       alu_overflow;
   logic       alu_carry;
   logic       counter_en;
   logic [2:0] dec_counter_out;
   logic [2:0] x;
   logic       en;
   logic [7:0] y_dec;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_cnt_dec_unit dut (
      .clk             (clk),
      .rst             (rst),
      .alu_fnselec     (alu_fnselec),
      .alu_a           (alu_a),
      .alu_b           (alu_b),
      .alu_res         (alu_res),
      .alu_zero        (alu_zero),
      .alu_overflow    (alu_overflow),
      .alu_carry       (alu_carry),
      .counter_en      (counter_en),
      .dec_counter_out (dec_counter_out),
      .x               (x),
      .en              (en),
      .y_dec           (y_dec)
   );

   typedef struct packed {
      logic [2:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] res;
      logic       z;
      logic       v;
      logic       c;
   } alu_vec_t;

   localparam int NVEC = 14;
   alu_vec_t vecs [NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   // Step to just after the next rising edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
      end
      #1;
   endtask

   task automatic alu_settle();
`ifdef ALU_OUTPUT_REG_EN
      tick(1);
`else
      #1;
`endif
   endtask

   initial begin
      // op, a, b, res, zero, overflow, carry
      vecs[0]  = '{3'b000, 4'h7, 4'h1, 4'h8, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{3'b000, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0, 1'b1};
      vecs[2]  = '{3'b000, 4'h8, 4'h8, 4'h0, 1'b1, 1'b1, 1'b1};
      vecs[3]  = '{3'b001, 4'h3, 4'h5, 4'hE, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{3'b001, 4'h5, 4'h5, 4'h0, 1'b1, 1'b0, 1'b1};
      vecs[5]  = '{3'b001, 4'h8, 4'h1, 4'h7, 1'b0, 1'b1, 1'b1};
      vecs[6]  = '{3'b110, 4'h8, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{3'b110, 4'h1, 4'h8, 4'h0, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{3'b111, 4'hA, 4'hA, 4'h1, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{3'b111, 4'h1, 4'h2, 4'h0, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{3'b010, 4'hC, 4'hA, 4'h3, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{3'b011, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{3'b100, 4'hC, 4'hA, 4'hE, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{3'b101, 4'hC, 4'hA, 4'h6, 1'b0, 1'b0, 1'b0};

      rst         = 1'b1;
      counter_en  = 1'b0;
      alu_fnselec = 3'b000;
      alu_a       = 4'h0;
      alu_b       = 4'h0;
      x           = 3'b000;
      en          = 1'b0;

      // ---------------- reset ----------------
      tick(2);
      chk("reset_cnt", 32'(dec_counter_out), 32'h7);
`ifdef ALU_OUTPUT_REG_EN
      chk("reset_res",  32'(alu_res),  32'h0);
      chk("reset_zero", 32'(alu_zero), 32'h0);
`endif
      rst = 1'b0;

      // ---------------- ALU table ----------------
      for (int i = 0; i < NVEC; i++) begin
         alu_fnselec = vecs[i].op;
         alu_a       = vecs[i].a;
         alu_b       = vecs[i].b;
         alu_settle();
         chk($sformatf("alu%0d_res op%0b a%0h b%0h", i, vecs[i].op, vecs[i].a, vecs[i].b),
             32'(alu_res), 32'(vecs[i].res));
         chk($sformatf("alu%0d_zero", i), 32'(alu_zero), 32'(vecs[i].z));
         chk($sformatf("alu%0d_ovf", i),  32'(alu_overflow), 32'(vecs[i].v));
         chk($sformatf("alu%0d_carry", i), 32'(alu_carry), 32'(vecs[i].c));
      end

`ifdef ALU_OUTPUT_REG_EN
      // ---------------- registered ALU latency ----------------
      alu_fnselec = 3'b010; alu_a = 4'hC; alu_b = 4'hA;
      tick(1);
      chk("reg_pre", 32'(alu_res), 32'h3);
      alu_fnselec = 3'b011;        // AND -> 8, must appear one edge later
      #2;
      chk("reg_hold", 32'(alu_res), 32'h3);
      tick(1);
      chk("reg_new", 32'(alu_res), 32'h8);
      alu_fnselec = 3'b000; alu_a = 4'h7; alu_b = 4'h1;   // would set overflow
      rst = 1'b1;
      tick(1);
      chk("reg_rst_res",  32'(alu_res),      32'h0);
      chk("reg_rst_zero", 32'(alu_zero),     32'h0);
      chk("reg_rst_ovf",  32'(alu_overflow), 32'h0);
      chk("reg_rst_cry",  32'(alu_carry),    32'h0);
      rst = 1'b0;
`endif

      // ---------------- counter ----------------
      rst = 1'b1;
      tick(1);
      chk("cnt_rst", 32'(dec_counter_out), 32'h7);
      rst = 1'b0;
      counter_en = 1'b1;
      tick(1);
      chk("cnt_1", 32'(dec_counter_out), 32'h6);
      tick(2);
      chk("cnt_3", 32'(dec_counter_out), 32'h4);
      tick(4);
      chk("cnt_7", 32'(dec_counter_out), 32'h0);
      tick(1);
      chk("cnt_wrap", 32'(dec_counter_out), 32'h7);
      counter_en = 1'b0;
      tick(5);
      chk("cnt_hold", 32'(dec_counter_out), 32'h7);
      counter_en = 1'b1;
      tick(2);
      chk("cnt_mid", 32'(dec_counter_out), 32'h5);
      rst = 1'b1;               // reset wins over enable
      tick(1);
      chk("cnt_rst_en", 32'(dec_counter_out), 32'h7);
      rst = 1'b0;
      counter_en = 1'b0;
      tick(1);
      chk("cnt_after_rst", 32'(dec_counter_out), 32'h7);

      // ---------------- decoder ----------------
      en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         logic [7:0] exp_y;
         x = 3'(i);
         exp_y = 8'h01 << i;
         #1;
         chk($sformatf("dec_en_x%0d", i), 32'(y_dec), 32'(exp_y));
      end
      x = 3'b101;
      #1;
      chk("dec_x5", 32'(y_dec), 32'h20);
      en = 1'b0;
      for (int i = 0; i < 8; i += 3) begin
         x = 3'(i);
         #1;
         chk($sformatf("dec_dis_x%0d", i), 32'(y_dec), 32'h00);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute guard so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
